// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO multiply/divide unit. 1-cycle MULT/MULTU, 32-cycle restoring DIV/DIVU.
// Ports: clk, rst, start, op, a, b, hilo_we, hilo_wdata, flush -> busy, done, hilo{HI,LO}.
module hilo_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_we,
  input  logic [63:0] hilo_wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [63:0] hilo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem;
  logic [4:0]  cnt;
  logic        sgn;
  logic        qneg;
  logic        rneg;

  logic        idle;
  logic        accept;
  logic        last;
  logic [63:0] prod;
  logic [32:0] sh;
  logic        ge;
  logic [31:0] new_rem;
  logic [31:0] new_q;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign idle   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept = idle && start && !flush;
  assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done   = (state_q == S_DONE);
  assign last   = (state_q == S_DIV) && (cnt == 5'd31);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) state_d = op[1] ? S_DIV : S_MUL;
        end
        S_MUL: state_d = S_DONE;
        S_DIV: if (cnt == 5'd31) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operands are sign-extended (or zero-extended) to 64 bits so one
  // unsigned multiply yields the correct low 64 bits in both modes.
  always_comb begin
    if (sgn) prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else     prod = {32'b0, a_q} * {32'b0, b_q};
  end

  // One restoring step: a_q shifts the dividend out and the quotient in.
  always_comb begin
    sh      = {rem, a_q[31]};
    ge      = sh >= {1'b0, b_q};
    new_rem = ge ? (sh[31:0] - b_q) : sh[31:0];
    new_q   = {a_q[30:0], ge};
    q_fix   = qneg ? (32'd0 - new_q) : new_q;
    r_fix   = rneg ? (32'd0 - new_rem) : new_rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      rem  <= '0;
      cnt  <= '0;
      sgn  <= 1'b0;
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else if (accept) begin
      sgn <= ~op[0];
      rem <= '0;
      cnt <= '0;
      if (op[1] && !op[0]) begin
        a_q  <= a[31] ? (32'd0 - a) : a;
        b_q  <= b[31] ? (32'd0 - b) : b;
        // Divide-by-zero keeps the all-ones quotient unnegated.
        qneg <= (a[31] ^ b[31]) && (b != 32'd0);
        rneg <= a[31];
      end else begin
        a_q  <= a;
        b_q  <= b;
        qneg <= 1'b0;
        rneg <= 1'b0;
      end
    end else if (state_q == S_DIV) begin
      a_q <= new_q;
      rem <= new_rem;
      cnt <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo <= '0;
    end else if (!flush && state_q == S_MUL) begin
      hilo <= prod;
    end else if (!flush && last) begin
      hilo <= {r_fix, q_fix};
    end else if (idle && hilo_we) begin
      hilo <= hilo_wdata;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: randomized and directed checks of hilo_mdu against an arithmetic model.
// Drives and samples on the falling clock edge.
module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [63:0] hilo;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] cur;

  hilo_mdu dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .hilo       (hilo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin
        p = sx * sy;
        res = p;
      end
      2'd1: res = {32'b0, x} * {32'b0, y};
      2'd2: begin
        if (y == 0) begin
          res = {x, 32'hFFFFFFFF};
        end else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else        res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Called just after a falling edge; returns at the falling edge where done shows.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input string tag);
    int n;
    logic [63:0] exp;
    exp = model(o, x, y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy"}, {63'b0, busy}, 64'd1);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " lat"}, 64'(n), o[1] ? 64'd32 : 64'd1);
    chk({tag, " done"}, {63'b0, done}, 64'd1);
    chk({tag, " hilo"}, hilo, exp);
    cur = exp;
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    chk({tag, " done_clr"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int n;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    hilo_we = 1'b0;
    hilo_wdata = '0;
    flush = 1'b0;
    cur = '0;
    repeat (2) @(negedge clk);
    chk("rst hilo", hilo, 64'd0);
    chk("rst busy", {63'b0, busy}, 64'd0);
    chk("rst done", {63'b0, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd0, 32'hFFFFFFFE, 32'd3, "mult");
    settle("mult");
    run_op(2'd1, 32'hFFFFFFFE, 32'd3, "multu");
    settle("multu");
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, "div");
    settle("div");
    run_op(2'd3, 32'd100, 32'd7, "divu");
    settle("divu");
    run_op(2'd3, 32'h1234, 32'd0, "divu0");
    settle("divu0");
    run_op(2'd2, 32'hFFFFFFF9, 32'd0, "div0");
    settle("div0");
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, "ovf");
    // start accepted while in DONE
    run_op(2'd0, 32'd7, 32'hFFFFFFFB, "b2b");
    settle("b2b");

    // flush mid-division
    start = 1'b1; op = 2'd2; a = 32'd12345; b = 32'd17;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {63'b0, busy}, 64'd0);
    chk("flush done", {63'b0, done}, 64'd0);
    chk("flush hilo", hilo, cur);
    n = 0;
    repeat (35) begin
      @(negedge clk);
      if (done || hilo !== cur) n++;
    end
    chk("flush quiet", 64'(n), 64'd0);
    // flush with start ignored
    start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush start", {63'b0, busy}, 64'd0);
    run_op(2'd3, 32'd99, 32'd10, "post_flush");
    settle("post_flush");

    // direct write while idle
    hilo_we = 1'b1; hilo_wdata = 64'h1_00000002;
    @(negedge clk);
    hilo_we = 1'b0;
    chk("we idle", hilo, 64'h00000001_00000002);
    cur = hilo_wdata;

    // write during DIV ignored
    start = 1'b1; op = 2'd3; a = 32'd50; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    hilo_we = 1'b1; hilo_wdata = 64'hDEAD_BEEF_0000_1111;
    @(negedge clk);
    hilo_we = 1'b0;
    chk("we busy", hilo, cur);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("we busy res", hilo, model(2'd3, 32'd50, 32'd3));
    settle("we busy");

    // write and start together: write lands first, result later
    hilo_we = 1'b1; hilo_wdata = 64'h0123_4567_89AB_CDEF;
    run_op(2'd2, 32'hFFFF0000, 32'd77, "we_start");
    hilo_we = 1'b0;
    settle("we_start");
    hilo_we = 1'b1; hilo_wdata = 64'h0123_4567_89AB_CDEF;
    start = 1'b1; op = 2'd3; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0; hilo_we = 1'b0;
    chk("we_start imm", hilo, 64'h0123_4567_89AB_CDEF);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("we_start res", hilo, 64'h00000001_00000004);
    settle("we_start2");

    // asynchronous reset mid-division
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst hilo", hilo, 64'd0);
    chk("arst busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || hilo !== 64'd0) n++;
    end
    chk("arst quiet", 64'(n), 64'd0);
    cur = '0;

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        hilo_we = 1'b1;
        hilo_wdata = {$urandom, $urandom};
        @(negedge clk);
        hilo_we = 1'b0;
        chk("rnd we", hilo, hilo_wdata);
      end
      run_op(ro, ra, rb, "rnd");
      if ($urandom_range(0, 1) == 0) settle("rnd");
    end
    settle("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
